// File: rtl/z80_bus_pkg.sv
// Command encodings, bus phase enumeration and helpers shared by the Z80 bus initiator.
package z80_bus_pkg;

    localparam int WAIT_W = 8;

    localparam logic [2:0] CMD_MEMRD = 3'd0;
    localparam logic [2:0] CMD_MEMWR = 3'd1;
    localparam logic [2:0] CMD_IORD  = 3'd2;
    localparam logic [2:0] CMD_IOWR  = 3'd3;
    localparam logic [2:0] CMD_M1    = 3'd4;

    // One phase per clk: every T-state is an H phase followed by an L phase.
    typedef enum logic [3:0] {
        PH_IDLE,
        PH_T1H,
        PH_T1L,
        PH_T2H,
        PH_T2L,
        PH_TWH,
        PH_TWL,
        PH_T3H,
        PH_T3L,
        PH_T4H,
        PH_T4L,
        PH_RSP
    } phase_e;

    function automatic logic is_io(input logic [2:0] cmd);
        return (cmd == CMD_IORD) || (cmd == CMD_IOWR);
    endfunction

    function automatic logic is_reserved(input logic [2:0] cmd);
        return cmd > CMD_M1;
    endfunction

    function automatic logic is_read(input logic [2:0] cmd);
        return (cmd == CMD_MEMRD) || (cmd == CMD_IORD) || (cmd == CMD_M1);
    endfunction

endpackage

// File: rtl/z80_bus_initiator.sv
// Z80 bus-cycle initiator: runs one MEMRD/MEMWR/IORD/IOWR/M1 cycle per request with
// half-T-state phase sequencing, wait-state handling, refresh and a response port.
module z80_bus_initiator
    import z80_bus_pkg::*;
#(
    parameter int WAIT_LIMIT   = 255,
    parameter int IO_AUTO_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_cmd,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        z80_clk,
    output logic [15:0] adr,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        mreq_b,
    output logic        iorq_b,
    output logic        rd_b,
    output logic        wr_b,
    output logic        m1_b,
    output logic        rfsh_b,
    input  logic        ready,
    output logic        busy
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_LIMIT[WAIT_W-1:0];
    localparam logic [1:0]        AUTO_N   = IO_AUTO_WAIT[1:0];

    phase_e             phase_q, phase_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [15:0]        adr_q, adr_d;
    logic [7:0]         data_out_q, data_out_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [1:0]         auto_q, auto_d;
    logic               err_q, err_d;
    logic [7:0]         cap_q, cap_d;
    logic [7:0]         r_q, r_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;
    logic               z80_clk_q, z80_clk_d;
    logic               data_oe_q, data_oe_d;
    logic               mreq_b_q, mreq_b_d;
    logic               iorq_b_q, iorq_b_d;
    logic               rd_b_q, rd_b_d;
    logic               wr_b_q, wr_b_d;
    logic               m1_b_q, m1_b_d;
    logic               rfsh_b_q, rfsh_b_d;
    logic               win_t1l_t3h, win_t2h_t3h, win_t1l_tw, win_t1l_t3l, win_t2l_t3h;

    always_comb begin
        phase_d    = phase_q;
        cmd_d      = cmd_q;
        adr_d      = adr_q;
        data_out_d = data_out_q;
        wait_d     = wait_q;
        auto_d     = auto_q;
        err_d      = err_q;
        cap_d      = cap_q;
        r_d        = r_q;
        rdata_d    = rdata_q;

        case (phase_q)
            PH_IDLE, PH_RSP: begin
                phase_d = PH_IDLE;
                if (req_valid) begin
                    cmd_d      = req_cmd;
                    data_out_d = req_wdata;
                    wait_d     = '0;
                    auto_d     = '0;
                    err_d      = is_reserved(req_cmd);
                    if (is_reserved(req_cmd)) begin
                        phase_d = PH_RSP;
                    end else begin
                        phase_d = PH_T1H;
                        adr_d   = req_addr;
                    end
                end
            end
            PH_T1H: phase_d = PH_T1L;
            PH_T1L: phase_d = PH_T2H;
            PH_T2H: phase_d = PH_T2L;
            // IO cycles burn their automatic waits first; READY is only looked at afterwards.
            PH_T2L, PH_TWL: begin
                if (is_io(cmd_q) && (auto_q < AUTO_N)) begin
                    auto_d  = auto_q + 2'd1;
                    phase_d = PH_TWH;
                end else if (ready) begin
                    phase_d = PH_T3H;
                end else if (wait_q == WAIT_MAX) begin
                    err_d   = 1'b1;
                    phase_d = PH_T3H;
                end else begin
                    wait_d  = wait_q + 8'd1;
                    phase_d = PH_TWH;
                end
            end
            PH_TWH: phase_d = PH_TWL;
            PH_T3H: begin
                phase_d = PH_T3L;
                cap_d   = data_in;
            end
            PH_T3L: phase_d = (cmd_q == CMD_M1) ? PH_T4H : PH_RSP;
            PH_T4H: phase_d = PH_T4L;
            PH_T4L: begin
                phase_d = PH_RSP;
                r_d     = {r_q[7], r_q[6:0] + 7'd1};
            end
            default: phase_d = PH_IDLE;
        endcase

        if ((phase_d == PH_T3H) && (cmd_q == CMD_M1)) begin
            adr_d = {8'h00, r_q};
        end

        if (phase_d == PH_RSP) begin
            if (err_d) begin
                rdata_d = 8'hFF;
            end else if (is_read(cmd_d)) begin
                rdata_d = cap_q;
            end
        end

        // Outputs are decoded from the phase being entered so they change at phase start.
        win_t1l_t3h = phase_d inside {PH_T1L, PH_T2H, PH_T2L, PH_TWH, PH_TWL, PH_T3H};
        win_t2h_t3h = phase_d inside {PH_T2H, PH_T2L, PH_TWH, PH_TWL, PH_T3H};
        win_t2l_t3h = phase_d inside {PH_T2L, PH_TWH, PH_TWL, PH_T3H};
        win_t1l_tw  = phase_d inside {PH_T1L, PH_T2H, PH_T2L, PH_TWH, PH_TWL};
        win_t1l_t3l = phase_d inside {PH_T1L, PH_T2H, PH_T2L, PH_TWH, PH_TWL, PH_T3H, PH_T3L};

        mreq_b_d  = 1'b1;
        iorq_b_d  = 1'b1;
        rd_b_d    = 1'b1;
        wr_b_d    = 1'b1;
        m1_b_d    = 1'b1;
        rfsh_b_d  = 1'b1;
        data_oe_d = 1'b0;

        case (cmd_d)
            CMD_MEMRD: begin
                mreq_b_d = !win_t1l_t3h;
                rd_b_d   = !win_t1l_t3h;
            end
            CMD_MEMWR: begin
                mreq_b_d  = !win_t1l_t3h;
                wr_b_d    = !win_t2l_t3h;
                data_oe_d = win_t1l_t3l;
            end
            CMD_IORD: begin
                iorq_b_d = !win_t2h_t3h;
                rd_b_d   = !win_t2h_t3h;
            end
            CMD_IOWR: begin
                iorq_b_d  = !win_t2h_t3h;
                wr_b_d    = !win_t2h_t3h;
                data_oe_d = win_t1l_t3l;
            end
            CMD_M1: begin
                m1_b_d   = !(win_t1l_tw || (phase_d == PH_T1H));
                mreq_b_d = !(win_t1l_tw || (phase_d inside {PH_T3L, PH_T4H}));
                rd_b_d   = !win_t1l_tw;
                rfsh_b_d = !(phase_d inside {PH_T3H, PH_T3L, PH_T4H, PH_T4L});
            end
            default: ;
        endcase

        case (phase_d)
            PH_T1H, PH_T2H, PH_TWH, PH_T3H, PH_T4H: z80_clk_d = 1'b1;
            PH_T1L, PH_T2L, PH_TWL, PH_T3L, PH_T4L: z80_clk_d = 1'b0;
            default:                                z80_clk_d = !z80_clk_q;
        endcase

        req_ready_d = (phase_d == PH_IDLE) || (phase_d == PH_RSP);
        busy_d      = !req_ready_d;
        rsp_valid_d = (phase_d == PH_RSP);
        rsp_err_d   = rsp_valid_d && err_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= PH_IDLE;
            cmd_q       <= '0;
            adr_q       <= '0;
            data_out_q  <= '0;
            wait_q      <= '0;
            auto_q      <= '0;
            err_q       <= 1'b0;
            cap_q       <= '0;
            r_q         <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            z80_clk_q   <= 1'b0;
            data_oe_q   <= 1'b0;
            mreq_b_q    <= 1'b1;
            iorq_b_q    <= 1'b1;
            rd_b_q      <= 1'b1;
            wr_b_q      <= 1'b1;
            m1_b_q      <= 1'b1;
            rfsh_b_q    <= 1'b1;
        end else begin
            phase_q     <= phase_d;
            cmd_q       <= cmd_d;
            adr_q       <= adr_d;
            data_out_q  <= data_out_d;
            wait_q      <= wait_d;
            auto_q      <= auto_d;
            err_q       <= err_d;
            cap_q       <= cap_d;
            r_q         <= r_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            z80_clk_q   <= z80_clk_d;
            data_oe_q   <= data_oe_d;
            mreq_b_q    <= mreq_b_d;
            iorq_b_q    <= iorq_b_d;
            rd_b_q      <= rd_b_d;
            wr_b_q      <= wr_b_d;
            m1_b_q      <= m1_b_d;
            rfsh_b_q    <= rfsh_b_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;
    assign z80_clk   = z80_clk_q;
    assign adr       = adr_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign mreq_b    = mreq_b_q;
    assign iorq_b    = iorq_b_q;
    assign rd_b      = rd_b_q;
    assign wr_b      = wr_b_q;
    assign m1_b      = m1_b_q;
    assign rfsh_b    = rfsh_b_q;
    assign busy      = busy_q;

    a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (reset) !(!rd_b_q && !wr_b_q));
    a_mreq_iorq_exclusive: assert property (@(posedge clk) disable iff (reset) !(!mreq_b_q && !iorq_b_q));

endmodule
